raizing_rom_arb: RTL and testbench

RAIZING_ROM_ARB -- requirements
Module: raizing_rom_arb

---
 rtl/raizing_rom_pkg.sv | 39 +++
 rtl/raizing_rom_slot.sv | 42 ++++
 rtl/raizing_rom_arb.sv | 126 ++++++++++++
 tb/tb_raizing_rom_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raizing_rom_pkg.sv
// Raizing ROM arbiter shared definitions:
// client ids, arbiter states, round-robin pick.
package raizing_rom_pkg;

  localparam int N_CL = 3;

  localparam logic [1:0] CL_PRG = 2'd0;
  localparam logic [1:0] CL_Z80 = 2'd1;
  localparam logic [1:0] CL_PCM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  // First requester after 'last' in PRG->Z80->PCM order
  function automatic logic [1:0] rr_pick(
    input logic [2:0] req,
    input logic [1:0] last
  );
    logic [1:0] o0, o1, o2;
    case (last)
      CL_PRG: begin
        o0 = CL_Z80; o1 = CL_PCM; o2 = CL_PRG;
      end
      CL_Z80: begin
        o0 = CL_PCM; o1 = CL_PRG; o2 = CL_Z80;
      end
      default: begin
        o0 = CL_PRG; o1 = CL_Z80; o2 = CL_PCM;
      end
    endcase
    if (req[o0])      rr_pick = o0;
    else if (req[o1]) rr_pick = o1;
    else              rr_pick = o2;
  endfunction

endpackage

// File: rtl/raizing_rom_slot.sv
// One-word read cache for a single ROM client:
// tag compare, valid, data and OK generation.
module raizing_rom_slot
  import raizing_rom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [21:0] addr,
  input  logic        wr_en,
  input  logic [21:0] wr_tag,
  input  logic [15:0] wr_data,
  output logic        hit,
  output logic        ok,
  output logic [15:0] data
);

  logic        valid;
  logic [21:0] tag;
  logic        ok_q;

  assign hit = cs & valid & (tag == addr);
  // OK falls in the same cycle CS or the address moves away
  assign ok  = ok_q & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
      ok_q  <= 1'b0;
    end else begin
      ok_q <= hit;
      if (wr_en) begin
        valid <= 1'b1;
        tag   <= wr_tag;
        data  <= wr_data;
      end
    end
  end

endmodule

// File: rtl/raizing_rom_arb.sv
// SDRAM bank arbiter for 68K program, Z80 and
// OKI PCM ROMs with a one-word cache per client.
module raizing_rom_arb
  import raizing_rom_pkg::*;
#(
  parameter logic [21:0] PRG_OFFSET = 22'h000000,
  parameter logic [21:0] Z80_OFFSET = 22'h080000,
  parameter logic [21:0] PCM_OFFSET = 22'h0A0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PRG_CS,
  input  logic [18:0] PRG_ADDR,
  output logic [15:0] PRG_DOUT,
  output logic        PRG_OK,
  input  logic        Z80_CS,
  input  logic [16:0] Z80_ADDR,
  output logic [7:0]  Z80_DOUT,
  output logic        Z80_OK,
  input  logic        PCM_CS,
  input  logic [19:0] PCM_ADDR,
  output logic [7:0]  PCM_DOUT,
  output logic        PCM_OK,
  output logic [21:0] BA_ADDR,
  output logic        BA_RD,
  input  logic        BA_ACK,
  input  logic        BA_RDY,
  input  logic [15:0] DATA_READ
);

  logic [2:0][21:0] map;
  logic [2:0][15:0] data;
  logic [2:0]       cs, hit, ok, wr;
  logic [2:0]       miss;

  arb_state_t  state, state_d;
  logic [1:0]  gnt, gnt_d;
  logic [1:0]  last, last_d;
  logic [1:0]  pick;
  logic [21:0] addr_d;
  logic        rd_d;
  logic        fill;

  assign map[CL_PRG] = {3'b0, PRG_ADDR} + PRG_OFFSET;
  assign map[CL_Z80] = {6'b0, Z80_ADDR[16:1]} + Z80_OFFSET;
  assign map[CL_PCM] = {3'b0, PCM_ADDR[19:1]} + PCM_OFFSET;

  assign cs   = {PCM_CS, Z80_CS, PRG_CS};
  assign miss = cs & ~hit;
  assign pick = rr_pick(miss, last);
  assign wr   = fill ? (3'b001 << gnt) : 3'b000;

  for (genvar i = 0; i < N_CL; i++) begin : g_slot
    raizing_rom_slot u_slot (
      .clk    (CLK),
      .rst    (RESET),
      .cs     (cs[i]),
      .addr   (map[i]),
      .wr_en  (wr[i]),
      .wr_tag (BA_ADDR),
      .wr_data(DATA_READ),
      .hit    (hit[i]),
      .ok     (ok[i]),
      .data   (data[i])
    );
  end

  assign PRG_OK   = ok[CL_PRG];
  assign Z80_OK   = ok[CL_Z80];
  assign PCM_OK   = ok[CL_PCM];
  assign PRG_DOUT = data[CL_PRG];
  assign Z80_DOUT = Z80_ADDR[0] ? data[CL_Z80][15:8]
                                : data[CL_Z80][7:0];
  assign PCM_DOUT = PCM_ADDR[0] ? data[CL_PCM][15:8]
                                : data[CL_PCM][7:0];

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    last_d  = last;
    addr_d  = BA_ADDR;
    rd_d    = BA_RD;
    fill    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|miss) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = map[pick];
          rd_d    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (BA_ACK) begin
          rd_d    = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (BA_RDY) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      gnt     <= CL_PRG;
      last    <= CL_PCM;
      BA_ADDR <= '0;
      BA_RD   <= 1'b0;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      last    <= last_d;
      BA_ADDR <= addr_d;
      BA_RD   <= rd_d;
    end
  end

endmodule

// File: tb/tb_raizing_rom_arb.sv
// Scoreboard bench for raizing_rom_arb with an
// SDRAM responder and a memory reference model.
module tb_raizing_rom_arb;

  localparam logic [21:0] PRG_OFF = 22'h000000;
  localparam logic [21:0] Z80_OFF = 22'h080000;
  localparam logic [21:0] PCM_OFF = 22'h3FFFFF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [2:0]  cs_drv = 3'b000;
  logic [18:0] prg_addr = '0;
  logic [16:0] z80_addr = '0;
  logic [19:0] pcm_addr = '0;
  logic        BA_ACK, BA_RDY;
  logic [15:0] DATA_READ;
  logic [15:0] PRG_DOUT;
  logic [7:0]  Z80_DOUT, PCM_DOUT;
  logic        PRG_OK, Z80_OK, PCM_OK;
  logic [21:0] BA_ADDR;
  logic        BA_RD;

  raizing_rom_arb #(.PCM_OFFSET(PCM_OFF)) dut (
    .CLK(CLK), .RESET(RESET),
    .PRG_CS(cs_drv[0]), .PRG_ADDR(prg_addr),
    .PRG_DOUT(PRG_DOUT), .PRG_OK(PRG_OK),
    .Z80_CS(cs_drv[1]), .Z80_ADDR(z80_addr),
    .Z80_DOUT(Z80_DOUT), .Z80_OK(Z80_OK),
    .PCM_CS(cs_drv[2]), .PCM_ADDR(pcm_addr),
    .PCM_DOUT(PCM_DOUT), .PCM_OK(PCM_OK),
    .BA_ADDR(BA_ADDR), .BA_RD(BA_RD),
    .BA_ACK(BA_ACK), .BA_RDY(BA_RDY),
    .DATA_READ(DATA_READ)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] mem [logic [21:0]];
  logic [15:0] exp_q [3][$];
  logic [21:0] acc_q [$];
  int served [3] = '{0, 0, 0};
  int tgt [3] = '{0, 0, 0};
  int iss_cyc [3] = '{0, 0, 0};
  int lat [3] = '{0, 0, 0};
  int n_rd = 0;
  int fills = 0;
  int phase = 0;
  int ack_dly = 1;
  int rdy_dly = 1;
  bit rand_dly = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[7:0], a[15:8]} ^ {a[21:16], 10'h15A};
  endfunction

  function automatic logic [21:0] map_addr(input int c,
                                           input logic [19:0] a);
    longint w;
    case (c)
      0: w = longint'(a[18:0]) + longint'(PRG_OFF);
      1: w = longint'(a[16:1]) + longint'(Z80_OFF);
      default: w = longint'(a[19:1]) + longint'(PCM_OFF);
    endcase
    return 22'(w % 64'h400000);
  endfunction

  function automatic logic [15:0] expect_val(input int c,
                                             input logic [19:0] a);
    logic [15:0] d;
    d = mem_word(map_addr(c, a));
    if (c == 0) return d;
    return {8'h00, a[0] ? d[15:8] : d[7:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic issue(input int c, input logic [19:0] a);
    exp_q[c].push_back(expect_val(c, a));
    tgt[c] = served[c] + 1;
    iss_cyc[c] = cyc;
    case (c)
      0: prg_addr = a[18:0];
      1: z80_addr = a[16:0];
      default: pcm_addr = a;
    endcase
    cs_drv[c] = 1'b1;
  endtask

  task automatic wait_done(input int c);
    for (int i = 0; i < 300 && served[c] < tgt[c]; i++) tick();
    chk($sformatf("done%0d", c), 32'(served[c]), 32'(tgt[c]));
    if (served[c] < tgt[c]) begin
      exp_q[c].delete();
      served[c] = tgt[c];
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 300 && phase != p; i++) tick();
    chk("phase", 32'(phase), 32'(p));
  endtask

  task automatic wait_fills(input int n);
    for (int i = 0; i < 300 && fills < n; i++) tick();
    chk("fills", 32'(fills), 32'(n));
  endtask

  task automatic chk_acc(input string nm, input logic [21:0] e);
    logic [31:0] a;
    a = 32'hFFFF_FFFF;
    if (acc_q.size() > 0) a = 32'(acc_q.pop_front());
    chk(nm, a, 32'(e));
  endtask

  // SDRAM responder
  int m_ad, m_rd;
  logic [21:0] m_a;
  initial begin
    BA_ACK = 1'b0;
    BA_RDY = 1'b0;
    DATA_READ = 16'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (BA_RD && !RESET) begin
        m_a = BA_ADDR;
        acc_q.push_back(m_a);
        n_rd++;
        m_ad = rand_dly ? int'($urandom_range(1, 4)) : ack_dly;
        m_rd = rand_dly ? int'($urandom_range(1, 4)) : rdy_dly;
        phase = 1;
        for (int k = 1; k < m_ad; k++) begin
          @(posedge CLK);
          #1;
          chk("rd_hold", 32'({BA_RD, BA_ADDR}), 32'({1'b1, m_a}));
        end
        BA_ACK = 1'b1;
        @(posedge CLK);
        #1;
        BA_ACK = 1'b0;
        chk("rd_drop", 32'(BA_RD), 32'h0);
        phase = 2;
        for (int k = 1; k < m_rd; k++) begin
          @(posedge CLK);
          #1;
        end
        DATA_READ = mem_word(m_a);
        BA_RDY = 1'b1;
        @(posedge CLK);
        #1;
        BA_RDY = 1'b0;
        DATA_READ = 16'($urandom);
        chk("idle_pass", 32'(BA_RD), 32'h0);
        phase = 0;
        fills++;
      end
    end
  end

  // Monitor: pops an expectation whenever a client shows OK
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        for (int c = 0; c < 3; c++) begin
          logic o;
          logic [15:0] d;
          case (c)
            0: begin o = PRG_OK; d = PRG_DOUT; end
            1: begin o = Z80_OK; d = {8'h00, Z80_DOUT}; end
            default: begin o = PCM_OK; d = {8'h00, PCM_DOUT}; end
          endcase
          if (!cs_drv[c]) begin
            chk($sformatf("ok_nocs%0d", c), 32'(o), 32'h0);
          end else if (o && exp_q[c].size() > 0) begin
            chk($sformatf("dout%0d", c), 32'(d),
                32'(exp_q[c].pop_front()));
            lat[c] = cyc - iss_cyc[c];
            served[c]++;
          end
        end
      end
    end
  end

  task automatic rand_client(input int c);
    logic [19:0] a;
    for (int i = 0; i < 60; i++) begin
      case (c)
        0: a = 20'($urandom_range(0, 15));
        1: a = 20'($urandom_range(0, 31));
        default: a = ($urandom_range(0, 3) == 0)
                     ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                     : 20'($urandom_range(0, 31));
      endcase
      issue(c, a);
      wait_done(c);
      if ($urandom_range(0, 1) == 1) begin
        cs_drv[c] = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    cs_drv[c] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  int n0;
  initial begin
    mem[22'h000010] = 16'hBEEF;
    mem[22'h080001] = 16'h12AB;
    mem[22'h000000] = 16'h7E11;
    repeat (3) tick();
    chk("rst_rd", 32'(BA_RD), 32'h0);
    chk("rst_addr", 32'(BA_ADDR), 32'h0);
    chk("rst_ok", 32'({PCM_OK, Z80_OK, PRG_OK}), 32'h0);
    chk("rst_dout", 32'(PRG_DOUT), 32'h0);
    RESET = 1'b0;
    tick();

    ack_dly = 2;
    rdy_dly = 4;
    acc_q.delete();
    issue(0, 20'h00010);
    wait_done(0);
    chk_acc("prg_ba", 22'h000010);
    chk("prg_beef", 32'(PRG_DOUT), 32'hBEEF);
    chk("prg_ok", 32'(PRG_OK), 32'h1);
    cs_drv = 3'b000;
    tick();
    n0 = n_rd;
    issue(0, 20'h00010);
    wait_done(0);
    chk("prg_hit_lat", 32'(lat[0]), 32'h1);
    chk("prg_hit_nord", 32'(n_rd), 32'(n0));
    cs_drv = 3'b000;
    ack_dly = 1;
    rdy_dly = 1;
    tick();

    acc_q.delete();
    issue(1, 20'h00003);
    wait_done(1);
    chk_acc("z80_ba", 22'h080001);
    chk("z80_hi", 32'(Z80_DOUT), 32'h12);
    n0 = n_rd;
    issue(1, 20'h00002);
    wait_done(1);
    chk("z80_lo", 32'(Z80_DOUT), 32'hAB);
    chk("z80_nord", 32'(n_rd), 32'(n0));
    cs_drv = 3'b000;
    tick();

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    acc_q.delete();
    n0 = n_rd;
    issue(0, 20'h00100);
    issue(1, 20'h00200);
    issue(2, 20'h00300);
    wait_done(0);
    wait_done(1);
    wait_done(2);
    chk_acc("rr_first", map_addr(0, 20'h00100));
    chk_acc("rr_second", map_addr(1, 20'h00200));
    chk_acc("rr_third", map_addr(2, 20'h00300));
    chk("rr_pulses", 32'(n_rd), 32'(n0 + 3));
    cs_drv = 3'b000;
    tick();

    n0 = fills;
    pcm_addr = 20'h00444;
    cs_drv[2] = 1'b1;
    wait_phase(2);
    cs_drv[2] = 1'b0;
    wait_fills(n0 + 1);
    repeat (3) begin
      tick();
      chk("pcm_drop_ok", 32'(PCM_OK), 32'h0);
    end
    n0 = n_rd;
    issue(2, 20'h00444);
    wait_done(2);
    chk("pcm_hit_lat", 32'(lat[2]), 32'h1);
    chk("pcm_hit_nord", 32'(n_rd), 32'(n0));
    cs_drv = 3'b000;
    tick();

    rdy_dly = 8;
    n0 = fills;
    prg_addr = 19'h00777;
    cs_drv[0] = 1'b1;
    wait_phase(2);
    RESET = 1'b1;
    cs_drv = 3'b000;
    #1;
    chk("arst_rd", 32'(BA_RD), 32'h0);
    chk("arst_addr", 32'(BA_ADDR), 32'h0);
    chk("arst_ok", 32'({PCM_OK, Z80_OK, PRG_OK}), 32'h0);
    tick();
    RESET = 1'b0;
    wait_fills(n0 + 1);
    tick();
    chk("stray_ok", 32'({PCM_OK, Z80_OK, PRG_OK}), 32'h0);
    chk("stray_rd", 32'(BA_RD), 32'h0);
    rdy_dly = 1;
    n0 = n_rd;
    issue(0, 20'h00777);
    wait_done(0);
    chk("post_rst_miss", 32'(n_rd), 32'(n0 + 1));
    cs_drv = 3'b000;
    tick();

    acc_q.delete();
    issue(2, 20'h00002);
    wait_done(2);
    chk_acc("pcm_wrap", 22'h000000);
    cs_drv = 3'b000;
    tick();

    rand_dly = 1'b1;
    fork
      rand_client(0);
      rand_client(1);
      rand_client(2);
    join
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
